// File: rtl/prime_predict_ctrl.sv
// Prime-number prediction game controller: synchronizes a push button, captures a number,
// judges the player's prime guess and keeps score. Optional macro SCORE_SAT_EN saturates score at 15.
module prime_predict_ctrl #(
  parameter int unsigned HOLD_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       button_press,
  input  logic [3:0] num_in,
  input  logic       guess_prime,
  output logic [3:0] num_out,
  output logic       is_prime,
  output logic       result_valid,
  output logic       correct,
  output logic [3:0] score,
  output logic [3:0] rounds,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PRESSED = 3'd1,
    CAPTURE = 3'd2,
    EVAL    = 3'd3,
    SHOW    = 3'd4
  } state_t;

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

  state_t     state;
  state_t     next_state;
  logic       btn_meta;
  logic       btn_s;
  logic       guess_latched;
  logic [7:0] hold_cnt;
  logic       eval_prime;
  logic       eval_correct;
  logic [3:0] score_next;

  function automatic logic prime4(input logic [3:0] n);
    case (n)
      4'd2, 4'd3, 4'd5, 4'd7, 4'd11, 4'd13: prime4 = 1'b1;
      default:                              prime4 = 1'b0;
    endcase
  endfunction

  // Two-flop synchronizer; resets to the released level so reset cannot fake a press
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      btn_meta <= 1'b1;
      btn_s    <= 1'b1;
    end else begin
      btn_meta <= button_press;
      btn_s    <= btn_meta;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic and evaluation helpers
  always_comb begin
    next_state   = state;
    eval_prime   = prime4(num_out);
    eval_correct = (eval_prime == guess_latched);
`ifdef SCORE_SAT_EN
    if (score == 4'd15) begin
      score_next = 4'd15;
    end else begin
      score_next = score + 4'd1;
    end
`else
    score_next = score + 4'd1;
`endif
    case (state)
      IDLE: begin
        if (!btn_s) next_state = PRESSED;
        else        next_state = IDLE;
      end
      PRESSED: begin
        if (btn_s) next_state = CAPTURE;
        else       next_state = PRESSED;
      end
      CAPTURE: next_state = EVAL;
      EVAL:    next_state = SHOW;
      SHOW: begin
        if (hold_cnt == HOLD_LAST) next_state = IDLE;
        else                       next_state = SHOW;
      end
      default: next_state = IDLE;
    endcase
  end

  // Registered outputs: status flags follow the state being entered, results update in CAPTURE/EVAL
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      num_out       <= 4'd0;
      guess_latched <= 1'b0;
      is_prime      <= 1'b0;
      correct       <= 1'b0;
      score         <= 4'd0;
      rounds        <= 4'd0;
      result_valid  <= 1'b0;
      busy          <= 1'b0;
      hold_cnt      <= 8'd0;
    end else begin
      result_valid <= (next_state == SHOW);
      busy         <= (next_state != IDLE);
      case (state)
        CAPTURE: begin
          num_out       <= num_in;
          guess_latched <= guess_prime;
        end
        EVAL: begin
          is_prime <= eval_prime;
          correct  <= eval_correct;
          rounds   <= rounds + 4'd1;
          hold_cnt <= 8'd0;
          if (eval_correct) begin
            score <= score_next;
          end else begin
            score <= score;
          end
        end
        SHOW: begin
          if (next_state == IDLE) begin
            hold_cnt <= 8'd0;
          end else begin
            hold_cnt <= hold_cnt + 8'd1;
          end
        end
        default: begin
          num_out <= num_out;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prime_predict_ctrl.sv
// Self-checking bench for prime_predict_ctrl: a countdown-based round model checked every cycle,
// plus directed rounds with hand-computed literal expectations.
module tb_prime_predict_ctrl;

  localparam int HOLD = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       button_press = 1'b1;
  logic [3:0] num_in = 4'd0;
  logic       guess_prime = 1'b0;
  logic [3:0] num_out;
  logic       is_prime;
  logic       result_valid;
  logic       correct;
  logic [3:0] score;
  logic [3:0] rounds;
  logic       busy;

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_en = 1'b0;

  prime_predict_ctrl dut (
    .clk(clk), .rst(rst), .button_press(button_press), .num_in(num_in),
    .guess_prime(guess_prime), .num_out(num_out), .is_prime(is_prime),
    .result_valid(result_valid), .correct(correct), .score(score),
    .rounds(rounds), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int is_prime_ref(input int n);
    if (n < 2) return 0;
    for (int d = 2; d * d <= n; d++) begin
      if (n % d == 0) return 0;
    end
    return 1;
  endfunction

  // Behavioural model: button seen two edges late; a release starts a fixed busy window
  int m_b1 = 1, m_b2 = 1;
  int m_pressed = 0, m_left = 0;
  int m_num = 0, m_guess = 0, m_prime = 0, m_correct = 0, m_score = 0, m_rounds = 0;

  task automatic model_step();
    int bs;
    if (!rst) begin
      m_b1 = 1; m_b2 = 1; m_pressed = 0; m_left = 0;
      m_num = 0; m_guess = 0; m_prime = 0; m_correct = 0; m_score = 0; m_rounds = 0;
    end else begin
      bs = m_b2;
      m_b2 = m_b1;
      m_b1 = int'(button_press);
      if (m_left > 0) begin
        if (HOLD + 2 - m_left == 0) begin
          m_num = int'(num_in);
          m_guess = int'(guess_prime);
        end else if (HOLD + 2 - m_left == 1) begin
          m_prime = is_prime_ref(m_num);
          m_correct = (m_prime == m_guess) ? 1 : 0;
          m_rounds = (m_rounds + 1) % 16;
          if (m_correct == 1) begin
`ifdef SCORE_SAT_EN
            if (m_score < 15) m_score = m_score + 1;
`else
            m_score = (m_score + 1) % 16;
`endif
          end
        end
        m_left = m_left - 1;
      end else if (m_pressed == 1) begin
        if (bs == 1) begin
          m_pressed = 0;
          m_left = HOLD + 2;
        end
      end else if (bs == 0) begin
        m_pressed = 1;
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge rst);
      model_step();
    end
  end

  // Every-cycle comparison of all outputs against the model
  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        chk("m_num_out", int'(num_out), m_num);
        chk("m_is_prime", int'(is_prime), m_prime);
        chk("m_correct", int'(correct), m_correct);
        chk("m_score", int'(score), m_score);
        chk("m_rounds", int'(rounds), m_rounds);
        chk("m_busy", int'(busy), (m_pressed == 1 || m_left > 0) ? 1 : 0);
        chk("m_valid", int'(result_valid), (m_left > 0 && m_left <= HOLD) ? 1 : 0);
      end
    end
  end

  task automatic wait_valid(input int exp_lat);
    int t = 0;
    while (!result_valid && t < 40) begin
      @(negedge clk);
      t++;
    end
    chk("latency", t, exp_lat);
  endtask

  task automatic begin_round(input int n, input int g);
    @(negedge clk);
    button_press = 1'b0;
    guess_prime = g[0];
    num_in = 4'(n ^ 5);
    repeat (4) @(negedge clk);
    num_in = 4'(n);
    button_press = 1'b1;
    wait_valid(5);
  endtask

  task automatic finish_round(output int vc);
    int t = 0;
    vc = 0;
    while (result_valid && t < 300) begin
      vc++;
      @(negedge clk);
      t++;
    end
  endtask

  task automatic run_round(input int n, input int g, output int vc);
    begin_round(n, g);
    finish_round(vc);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_num_out"}, int'(num_out), 0);
    chk({tag, "_is_prime"}, int'(is_prime), 0);
    chk({tag, "_correct"}, int'(correct), 0);
    chk({tag, "_valid"}, int'(result_valid), 0);
    chk({tag, "_score"}, int'(score), 0);
    chk({tag, "_rounds"}, int'(rounds), 0);
    chk({tag, "_busy"}, int'(busy), 0);
  endtask

  initial begin
    int vc;
    int t;
    int gap;
    #2 rst = 1'b0;
    #1 cmp_en = 1'b1;
    check_zero("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    run_round(7, 1, vc);
    chk("r7_num_out", int'(num_out), 7);
    chk("r7_is_prime", int'(is_prime), 1);
    chk("r7_correct", int'(correct), 1);
    chk("r7_score", int'(score), 1);
    chk("r7_rounds", int'(rounds), 1);
    chk("r7_valid_len", vc, 16);

    run_round(9, 1, vc);
    chk("r9_is_prime", int'(is_prime), 0);
    chk("r9_correct", int'(correct), 0);
    chk("r9_score", int'(score), 1);
    chk("r9_rounds", int'(rounds), 2);

    run_round(0, 0, vc);
    chk("r0_correct", int'(correct), 1);
    chk("r0_score", int'(score), 2);
    run_round(1, 0, vc);
    chk("r1_is_prime", int'(is_prime), 0);
    chk("r1_correct", int'(correct), 1);
    chk("r1_score", int'(score), 3);
    chk("r1_rounds", int'(rounds), 4);

    // reset in SHOW
    begin_round(2, 1);
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1 check_zero("rst_show");
    @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst_show_score_after", int'(score), 0);
    chk("rst_show_busy_after", int'(busy), 0);

    run_round(3, 1, vc);
    chk("r3_score", int'(score), 1);
    chk("r3_rounds", int'(rounds), 1);

    // reset in PRESSED
    @(negedge clk);
    button_press = 1'b0;
    repeat (4) @(negedge clk);
    chk("pressed_busy", int'(busy), 1);
    #2 rst = 1'b0;
    #1 check_zero("rst_pressed");
    button_press = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    repeat (6) @(negedge clk);
    chk("rst_pressed_score_after", int'(score), 0);
    chk("rst_pressed_rounds_after", int'(rounds), 0);
    chk("rst_pressed_busy_after", int'(busy), 0);

    // button toggled in SHOW is ignored; a press held past SHOW restarts after one idle cycle
    begin_round(5, 0);
    repeat (2) @(negedge clk);
    button_press = 1'b0;
    repeat (3) @(negedge clk);
    button_press = 1'b1;
    repeat (3) @(negedge clk);
    button_press = 1'b0;
    t = 0;
    while (busy && t < 100) begin
      @(negedge clk);
      t++;
    end
    gap = 0;
    while (!busy && gap < 10) begin
      gap++;
      @(negedge clk);
    end
    chk("held_idle_gap", gap, 1);
    chk("r5_correct", int'(correct), 0);
    chk("r5_score", int'(score), 0);
    chk("r5_rounds", int'(rounds), 1);
    num_in = 4'd11;
    guess_prime = 1'b1;
    repeat (2) @(negedge clk);
    button_press = 1'b1;
    wait_valid(5);
    finish_round(vc);
    chk("r11_num_out", int'(num_out), 11);
    chk("r11_score", int'(score), 1);
    chk("r11_rounds", int'(rounds), 2);

    // 16 correct rounds from reset
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      run_round(i, is_prime_ref(i), vc);
    end
`ifdef SCORE_SAT_EN
    chk("sixteen_score", int'(score), 15);
`else
    chk("sixteen_score", int'(score), 0);
`endif
    chk("sixteen_rounds", int'(rounds), 0);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
